// File: rtl/jtdd_vtimer_pkg.sv
// Shared timing constants and types for the JTDD video timer.
// Defaults describe the 384x272 raster used by the rest of the video chain.
package jtdd_vtimer_pkg;

   localparam int CW = 9;

   localparam int HTOTAL_DEF   = 384;
   localparam int HB_START_DEF = 256;
   localparam int HS_START_DEF = 304;
   localparam int HS_END_DEF   = 336;
   localparam int VTOTAL_DEF   = 272;
   localparam int VB_START_DEF = 240;
   localparam int VS_START_DEF = 248;
   localparam int VS_END_DEF   = 252;
   localparam logic [3:0] FIRQ_MASK_DEF = 4'hF;

   typedef logic [CW-1:0] cnt_t;

   typedef struct packed {
      logic hbl;
      logic vbl;
      logic hs;
      logic vs;
      logic hinit;
      logic vinit;
      logic nmi_stb;
      logic firq_stb;
   } vflags_t;

   localparam vflags_t FLAGS_RST = '{hbl: 1'b0, vbl: 1'b0, hs: 1'b0, vs: 1'b0,
                                     hinit: 1'b1, vinit: 1'b1,
                                     nmi_stb: 1'b0, firq_stb: 1'b0};

   function automatic logic in_range(cnt_t x, cnt_t lo, cnt_t hi);
      return (x >= lo) && (x < hi);
   endfunction

endpackage

// File: rtl/jtdd_vtimer_if.sv
// Video timing bundle shared between the timer and its consumers.
interface jtdd_vtimer_if;
   import jtdd_vtimer_pkg::*;

   // pxl_cen qualifies every counter step; there is no back-pressure. H/V and
   // all decodes change only on clk edges where pxl_cen is high, while the
   // strobes are single-clk pulses that never wait for a consumer.
   logic pxl_cen;
   cnt_t H;
   cnt_t V;
   logic HBL;
   logic VBL;
   logic HS;
   logic VS;
   logic Hinit;
   logic Vinit;
   logic nmi_stb;
   logic firq_stb;

   modport master (
      input  pxl_cen,
      output H, V, HBL, VBL, HS, VS, Hinit, Vinit, nmi_stb, firq_stb
   );

   modport slave (
      output pxl_cen,
      input  H, V, HBL, VBL, HS, VS, Hinit, Vinit, nmi_stb, firq_stb
   );

endinterface

// File: rtl/jtdd_vtimer_cnt.sv
// Wrap counter 0..TOTAL-1 with enable; carry marks the step that wraps to 0.
// cnt_nxt exposes the value the register takes on this edge.
module jtdd_vtimer_cnt
   import jtdd_vtimer_pkg::*;
#(
   parameter int TOTAL = 384
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output cnt_t cnt,
   output cnt_t cnt_nxt,
   output logic carry
);

   localparam cnt_t LAST = cnt_t'(TOTAL - 1);

   always_comb begin
      carry   = en && (cnt == LAST);
      cnt_nxt = cnt;
      if (en) cnt_nxt = carry ? '0 : cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nxt;
   end

endmodule

// File: rtl/jtdd_vtimer.sv
// JTDD video timing generator: H/V counters plus registered blanking, sync,
// init markers and CPU interrupt strobes, all decoded from the next counts.
module jtdd_vtimer
   import jtdd_vtimer_pkg::*;
#(
   parameter int HTOTAL   = HTOTAL_DEF,
   parameter int HB_START = HB_START_DEF,
   parameter int HS_START = HS_START_DEF,
   parameter int HS_END   = HS_END_DEF,
   parameter int VTOTAL   = VTOTAL_DEF,
   parameter int VB_START = VB_START_DEF,
   parameter int VS_START = VS_START_DEF,
   parameter int VS_END   = VS_END_DEF,
   parameter logic [3:0] FIRQ_MASK = FIRQ_MASK_DEF
) (
   input  logic clk,
   input  logic rst,
   jtdd_vtimer_if.master vt
);

   localparam cnt_t HB  = cnt_t'(HB_START);
   localparam cnt_t HSS = cnt_t'(HS_START);
   localparam cnt_t HSE = cnt_t'(HS_END);
   localparam cnt_t VB  = cnt_t'(VB_START);
   localparam cnt_t VSS = cnt_t'(VS_START);
   localparam cnt_t VSE = cnt_t'(VS_END);

   cnt_t    h, h_nxt, v, v_nxt;
   logic    h_carry, v_carry;
   vflags_t flags;

   jtdd_vtimer_cnt #(.TOTAL(HTOTAL)) u_hcnt (
      .clk     (clk),
      .rst     (rst),
      .en      (vt.pxl_cen),
      .cnt     (h),
      .cnt_nxt (h_nxt),
      .carry   (h_carry)
   );

   jtdd_vtimer_cnt #(.TOTAL(VTOTAL)) u_vcnt (
      .clk     (clk),
      .rst     (rst),
      .en      (h_carry),
      .cnt     (v),
      .cnt_nxt (v_nxt),
      .carry   (v_carry)
   );

   // h_carry already implies pxl_cen, so strobes only rise on a pixel step and
   // fall on the very next clk whatever pxl_cen does.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags <= FLAGS_RST;
      end else begin
         flags.nmi_stb  <= h_carry && (v_nxt == VB);
         flags.firq_stb <= h_carry && (v_nxt[3:0] == FIRQ_MASK) && (v_nxt < VB);
         if (vt.pxl_cen) begin
            flags.hbl   <= h_nxt >= HB;
            flags.vbl   <= v_nxt >= VB;
            flags.hs    <= in_range(h_nxt, HSS, HSE);
            flags.vs    <= in_range(v_nxt, VSS, VSE);
            flags.hinit <= h_carry;
            flags.vinit <= v_carry;
         end
      end
   end

   assign vt.H        = h;
   assign vt.V        = v;
   assign vt.HBL      = flags.hbl;
   assign vt.VBL      = flags.vbl;
   assign vt.HS       = flags.hs;
   assign vt.VS       = flags.vs;
   assign vt.Hinit    = flags.hinit;
   assign vt.Vinit    = flags.vinit;
   assign vt.nmi_stb  = flags.nmi_stb;
   assign vt.firq_stb = flags.firq_stb;

endmodule
